// File: rtl/keypad_pkg.sv
// Shared types, constants and helpers for the 4x4 keypad scanner.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int COL_W    = 2;

    // Keys below this code belong to player 1, the rest to player 2.
    localparam logic [3:0] PLAYER_SPLIT = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_HELD  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        FR_NONE  = 2'd0,
        FR_ONE   = 2'd1,
        FR_MULTI = 2'd2
    } frame_res_t;

    function automatic logic [2:0] count_low(input logic [NUM_ROWS-1:0] low);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < NUM_ROWS; i++) n = n + {2'b00, low[i]};
        return n;
    endfunction

    function automatic logic [1:0] first_low(input logic [NUM_ROWS-1:0] low);
        logic [1:0] idx;
        idx = '0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) if (low[i]) idx = 2'(i);
        return idx;
    endfunction

endpackage

// File: rtl/keypad_col_driver.sv
// Column rotation timer: holds each column low for SCAN_DIV cycles and
// strobes the row-sample point and the end of each 4-column frame.
module keypad_col_driver
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 1000
) (
    input  logic             clk,
    input  logic             rst,
    output logic [COL_W-1:0] col,
    output logic [3:0]       col_out,
    output logic             sample_en,
    output logic             frame_end
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);

    logic [SW-1:0] slot;

    always_ff @(posedge clk) begin
        if (!rst) begin
            slot <= '0;
            col  <= '0;
        end else if (slot == SLOT_LAST) begin
            slot <= '0;
            col  <= col + 1'b1;
        end else begin
            slot <= slot + 1'b1;
        end
    end

    // Sampling on the last slot cycle gives rows time to settle through the synchronizer.
    assign sample_en = (slot == SLOT_LAST);
    assign frame_end = sample_en && (col == COL_W'(NUM_COLS - 1));
    assign col_out   = ~(4'b0001 << col);

endmodule

// File: rtl/keypad_scan.sv
// Keypad scanner top: row synchronizer, per-frame row accumulator,
// debounce FSM and registered key/player outputs.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held,
    output logic [2:0] value_player1,
    output logic [2:0] value_player2,
    output state_t     fsm_state
);

    localparam int CNT_W = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE);

    logic [COL_W-1:0] col;
    logic             sample_en;
    logic             frame_end;

    keypad_col_driver #(.SCAN_DIV(SCAN_DIV)) u_col_driver (
        .clk       (clk),
        .rst       (rst),
        .col       (col),
        .col_out   (col_out),
        .sample_en (sample_en),
        .frame_end (frame_end)
    );

    logic [3:0] row_s1, row_s2;

    always_ff @(posedge clk) begin
        if (!rst) begin
            row_s1 <= 4'b1111;
            row_s2 <= 4'b1111;
        end else begin
            row_s1 <= row_in;
            row_s2 <= row_s1;
        end
    end

    // Hit count saturates at 2: anything above one low row-bit per frame is MULTI.
    logic [1:0] acc_hits, m_hits;
    logic [3:0] acc_code, m_code;
    logic [2:0] s_hits, s_sum;
    frame_res_t fres;

    always_comb begin
        s_hits = count_low(~row_s2);
        s_sum  = {1'b0, acc_hits} + s_hits;
        m_hits = acc_hits;
        m_code = acc_code;
        if (sample_en) begin
            m_hits = (s_sum >= 3'd2) ? 2'd2 : s_sum[1:0];
            if (acc_hits == 2'd0 && s_hits == 3'd1) m_code = {first_low(~row_s2), col};
        end
        fres = FR_NONE;
        if (m_hits == 2'd1)      fres = FR_ONE;
        else if (m_hits >= 2'd2) fres = FR_MULTI;
    end

    always_ff @(posedge clk) begin
        if (!rst || frame_end) begin
            acc_hits <= '0;
            acc_code <= '0;
        end else if (sample_en) begin
            acc_hits <= m_hits;
            acc_code <= m_code;
        end
    end

    state_t           state, state_n;
    logic [3:0]       cand, cand_n, code_n, acc_key;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic             valid_n, held_n, do_accept;
    logic [2:0]       v1_n, v2_n;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= ST_IDLE;
            cand          <= '0;
            cnt           <= '0;
            key_code      <= '0;
            key_valid     <= 1'b0;
            key_held      <= 1'b0;
            value_player1 <= '0;
            value_player2 <= '0;
        end else begin
            state         <= state_n;
            cand          <= cand_n;
            cnt           <= cnt_n;
            key_code      <= code_n;
            key_valid     <= valid_n;
            key_held      <= held_n;
            value_player1 <= v1_n;
            value_player2 <= v2_n;
        end
    end

    always_comb begin
        state_n   = state;
        cand_n    = cand;
        cnt_n     = cnt;
        code_n    = key_code;
        valid_n   = 1'b0;
        held_n    = key_held;
        v1_n      = value_player1;
        v2_n      = value_player2;
        do_accept = 1'b0;
        acc_key   = cand;
        cnt_inc   = cnt + 1'b1;
        if (frame_end) begin
            case (state)
                ST_IDLE: begin
                    if (fres == FR_ONE) begin
                        cand_n = m_code;
                        if (DEBOUNCE == 1) begin
                            do_accept = 1'b1;
                            acc_key   = m_code;
                            state_n   = ST_HELD;
                            cnt_n     = '0;
                        end else begin
                            state_n = ST_PRESS;
                            cnt_n   = CNT_W'(1);
                        end
                    end
                end
                ST_PRESS: begin
                    if (fres == FR_ONE && m_code == cand) begin
                        if (cnt_inc == CNT_DONE) begin
                            do_accept = 1'b1;
                            state_n   = ST_HELD;
                            cnt_n     = '0;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end else if (fres == FR_ONE) begin
                        cand_n = m_code;
                        cnt_n  = CNT_W'(1);
                    end else begin
                        state_n = ST_IDLE;
                        cnt_n   = '0;
                    end
                end
                ST_HELD: begin
                    if (fres == FR_ONE && m_code == key_code) begin
                        cnt_n = '0;
                    end else if (cnt_inc == CNT_DONE) begin
                        state_n = ST_IDLE;
                        cnt_n   = '0;
                        held_n  = 1'b0;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
        if (do_accept) begin
            code_n  = acc_key;
            valid_n = 1'b1;
            held_n  = 1'b1;
            if (acc_key < PLAYER_SPLIT) v1_n = acc_key[2:0];
            else                        v2_n = acc_key[2:0];
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with SCAN_DIV=4, DEBOUNCE=3 (16-cycle frames).
module tb_keypad_scan;
    import keypad_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  row_in;
    logic [15:0] keys = 16'h0000;
    logic [3:0]  col_out;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_held;
    logic [2:0]  value_player1;
    logic [2:0]  value_player2;
    state_t      fsm_state;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int base = 0;
    int pulse_cnt = 0;
    int pulse_base = 0;
    int dbl_cnt = 0;
    logic prev_valid = 1'b0;

    keypad_scan #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .row_in        (row_in),
        .col_out       (col_out),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .key_held      (key_held),
        .value_player1 (value_player1),
        .value_player2 (value_player2),
        .fsm_state     (fsm_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Physical keypad: a pressed key pulls its row low while its column is driven.
    always_comb begin
        row_in = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
    end

    always @(negedge clk) begin
        if (key_valid) begin
            pulse_cnt = pulse_cnt + 1;
            if (prev_valid) dbl_cnt = dbl_cnt + 1;
        end
        prev_valid = key_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int k);
        while (cyc - base < k) tick();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        repeat (n) tick();
        rst = 1'b1;
        base = cyc;
        pulse_base = pulse_cnt;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        // Reset and idle scan
        keys = 16'h0000;
        do_reset(3);
        chk("rst_col", 32'(col_out), 32'hE);
        chk("rst_valid", 32'(key_valid), 0);
        chk("rst_code", 32'(key_code), 0);
        chk("rst_held", 32'(key_held), 0);
        chk("rst_p1", 32'(value_player1), 0);
        chk("rst_p2", 32'(value_player2), 0);
        chk("rst_state", 32'(fsm_state), 32'(ST_IDLE));
        goto(3);  chk("scan_c0_end", 32'(col_out), 32'hE);
        goto(4);  chk("scan_c1", 32'(col_out), 32'hD);
        goto(8);  chk("scan_c2", 32'(col_out), 32'hB);
        goto(12); chk("scan_c3", 32'(col_out), 32'h7);
        goto(16); chk("scan_wrap", 32'(col_out), 32'hE);
        goto(64);
        chk("idle_pulses", 32'(pulse_cnt - pulse_base), 0);
        chk("idle_held", 32'(key_held), 0);
        chk("idle_code", 32'(key_code), 0);

        // Clean press of key 6, held 5 frames
        keys = 16'h0040;
        do_reset(2);
        goto(16); chk("k6_f1_state", 32'(fsm_state), 32'(ST_PRESS));
        goto(47); chk("k6_early", 32'(key_valid), 0);
        goto(48);
        chk("k6_valid", 32'(key_valid), 1);
        chk("k6_code", 32'(key_code), 6);
        chk("k6_held", 32'(key_held), 1);
        chk("k6_p1", 32'(value_player1), 6);
        chk("k6_p2", 32'(value_player2), 0);
        chk("k6_state", 32'(fsm_state), 32'(ST_HELD));
        goto(49); chk("k6_one_cycle", 32'(key_valid), 0);
        goto(80);
        chk("k6_pulses", 32'(pulse_cnt - pulse_base), 1);
        chk("k6_still_held", 32'(key_held), 1);

        // Release key 6, then press and release key 13
        keys = 16'h0000;
        goto(127); chk("k6_rel_early", 32'(key_held), 1);
        goto(128);
        chk("k6_rel", 32'(key_held), 0);
        chk("k6_rel_state", 32'(fsm_state), 32'(ST_IDLE));
        keys = 16'h2000;
        goto(175); chk("k13_early", 32'(key_valid), 0);
        goto(176);
        chk("k13_valid", 32'(key_valid), 1);
        chk("k13_code", 32'(key_code), 13);
        chk("k13_p2", 32'(value_player2), 5);
        chk("k13_p1", 32'(value_player1), 6);
        keys = 16'h0000;
        goto(223); chk("k13_held_before", 32'(key_held), 1);
        goto(224);
        chk("k13_held_drop", 32'(key_held), 0);
        chk("k13_rel_state", 32'(fsm_state), 32'(ST_IDLE));
        chk("k13_pulses", 32'(pulse_cnt - pulse_base), 2);

        // Bounce: key 2 present on odd frames only
        keys = 16'h0000;
        do_reset(2);
        for (int f = 0; f < 10; f++) begin
            keys = (f % 2 == 0) ? 16'h0004 : 16'h0000;
            goto(16 * (f + 1));
            if (f == 0) chk("bnc_f1_state", 32'(fsm_state), 32'(ST_PRESS));
            if (f == 1) chk("bnc_f2_state", 32'(fsm_state), 32'(ST_IDLE));
        end
        chk("bnc_pulses", 32'(pulse_cnt - pulse_base), 0);
        chk("bnc_state", 32'(fsm_state), 32'(ST_IDLE));

        // Keys 0 and 5 together: MULTI every frame
        keys = 16'h0021;
        do_reset(2);
        goto(16); chk("multi_f1_state", 32'(fsm_state), 32'(ST_IDLE));
        goto(96);
        chk("multi_pulses", 32'(pulse_cnt - pulse_base), 0);
        chk("multi_held", 32'(key_held), 0);
        chk("multi_state", 32'(fsm_state), 32'(ST_IDLE));

        // Reset pulse in the middle of debouncing key 6
        keys = 16'h0040;
        do_reset(2);
        goto(32); chk("mid_state", 32'(fsm_state), 32'(ST_PRESS));
        do_reset(1);
        chk("mid_rst_col", 32'(col_out), 32'hE);
        chk("mid_rst_state", 32'(fsm_state), 32'(ST_IDLE));
        goto(47); chk("mid_early", 32'(key_valid), 0);
        goto(48);
        chk("mid_valid", 32'(key_valid), 1);
        chk("mid_code", 32'(key_code), 6);
        chk("mid_p1", 32'(value_player1), 6);
        goto(64);
        chk("mid_pulses", 32'(pulse_cnt - pulse_base), 1);

        chk("no_double_valid", 32'(dbl_cnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
